// File: rtl/snes_dejitter_core.sv
// CSYNC de-jitter core: measures line length, gates GCLK on short lines
// and delays the CSYNC fall to match. Lock FSM, sync-loss, bypass, SC divider.
//
// Ports:
//   MCLK_i      master clock, all logic on rising edge
//   RST_N_i     synchronous active-low reset
//   BYPASS_i    1 = pass-through, no gating
//   CSYNC_i     raw async composite sync
//   CSYNC_o     de-jittered composite sync
//   GCLK_EN_o   registered clock-gate enable for MCLK & GCLK_EN_o
//   SC_o        divided subcarrier reference
//   LOCKED_o    lock FSM is in LOCKED
//   LINE_LEN_o  length of last accepted line in clocks
//   STRETCH_o   one-clock pulse when a stretch starts
module snes_dejitter_core #(
    parameter int CNT_W      = 11,
    parameter int H_MIN      = 1024,
    parameter int H_SHORT    = 1360,
    parameter int STRETCH    = 4,
    parameter int LOCK_LINES = 8,
    parameter int SC_DIV     = 3,
    parameter int SYNC_STG   = 2
) (
    input  logic             MCLK_i,
    input  logic             RST_N_i,
    input  logic             BYPASS_i,
    input  logic             CSYNC_i,
    output logic             CSYNC_o,
    output logic             GCLK_EN_o,
    output logic             SC_o,
    output logic             LOCKED_o,
    output logic [CNT_W-1:0] LINE_LEN_o,
    output logic             STRETCH_o
);

    localparam int GW  = $clog2(STRETCH + 1);
    localparam int LW  = $clog2(LOCK_LINES + 1);
    localparam int SCW = $clog2(SC_DIV + 1);

    localparam logic [CNT_W-1:0] H_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] H_MIN_C = CNT_W'(H_MIN);
    localparam logic [CNT_W-1:0] H_SHT_C = CNT_W'(H_SHORT);
    localparam logic [CNT_W-1:0] H_NOM_C = CNT_W'(H_SHORT + STRETCH);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                prev_q, prev_d;
    logic [CNT_W-1:0]    h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [GW-1:0]       g_cyc_q, g_cyc_d;
    logic [LW-1:0]       lock_q, lock_d;
    logic                cso_q, cso_d;
    logic                gclk_q, gclk_d;
    logic                st_q, st_d;
    logic [SCW-1:0]      sc_ctr_q, sc_ctr_d;
    logic                sc_q, sc_d;

    logic             csync_s;
    logic             fall;
    logic             h_sat;
    logic             line_start;
    logic             valid;
    logic             stretch_go;
    logic [CNT_W-1:0] len_now;

    always_comb begin
        csync_s    = sync_q[SYNC_STG-1];
        fall       = prev_q & ~csync_s;
        h_sat      = (h_cnt_q == H_MAX);
        line_start = fall && (h_cnt_q >= H_MIN_C) && !BYPASS_i;
        len_now    = h_sat ? H_MAX : h_cnt_q + 1'b1;
        valid      = (len_now == H_SHT_C) || (len_now == H_NOM_C);
        stretch_go = line_start && (state_q != IDLE) && (len_now == H_SHT_C);

        sync_d = {sync_q[SYNC_STG-2:0], CSYNC_i};
        prev_d = csync_s;

        h_cnt_d = h_cnt_q;
        if (BYPASS_i || line_start) begin
            h_cnt_d = '0;
        end else if (!h_sat) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        len_d = line_start ? len_now : len_q;

        state_d = state_q;
        lock_d  = lock_q;
        if (BYPASS_i) begin
            state_d = IDLE;
            lock_d  = '0;
        end else if (line_start) begin
            unique case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    lock_d  = '0;
                end
                TRACK: begin
                    if (!valid) begin
                        lock_d = '0;
                    end else begin
                        lock_d = lock_q + 1'b1;
                        if (lock_q == LW'(LOCK_LINES - 1)) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!valid) begin
                        state_d = TRACK;
                        lock_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    lock_d  = '0;
                end
            endcase
        end else if (h_sat) begin
            // no line start for 2^CNT_W clocks: sync lost
            state_d = IDLE;
            lock_d  = '0;
        end

        g_cyc_d = '0;
        if (!BYPASS_i) begin
            if (stretch_go) begin
                g_cyc_d = GW'(STRETCH);
            end else if (g_cyc_q != '0) begin
                g_cyc_d = g_cyc_q - 1'b1;
            end
        end

        gclk_d = BYPASS_i || (g_cyc_d == '0);
        st_d   = stretch_go;

        // hold CSYNC_o while the gate runs so its fall lands STRETCH later
        cso_d = cso_q;
        if (BYPASS_i || (!stretch_go && g_cyc_q <= GW'(1))) begin
            cso_d = csync_s;
        end

        sc_d     = sc_q;
        sc_ctr_d = sc_ctr_q + 1'b1;
        if (sc_ctr_q == SCW'(SC_DIV - 1)) begin
            sc_ctr_d = '0;
            sc_d     = ~sc_q;
        end
    end

    always_ff @(posedge MCLK_i) begin
        if (!RST_N_i) begin
            state_q  <= IDLE;
            sync_q   <= '1;
            prev_q   <= 1'b1;
            h_cnt_q  <= '0;
            len_q    <= '0;
            g_cyc_q  <= '0;
            lock_q   <= '0;
            cso_q    <= 1'b1;
            gclk_q   <= 1'b1;
            st_q     <= 1'b0;
            sc_ctr_q <= '0;
            sc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            h_cnt_q  <= h_cnt_d;
            len_q    <= len_d;
            g_cyc_q  <= g_cyc_d;
            lock_q   <= lock_d;
            cso_q    <= cso_d;
            gclk_q   <= gclk_d;
            st_q     <= st_d;
            sc_ctr_q <= sc_ctr_d;
            sc_q     <= sc_d;
        end
    end

    assign CSYNC_o    = cso_q;
    assign GCLK_EN_o  = gclk_q;
    assign SC_o       = sc_q;
    assign LOCKED_o   = (state_q == LOCKED);
    assign LINE_LEN_o = len_q;
    assign STRETCH_o  = st_q;

endmodule

// File: tb/tb_snes_dejitter_core.sv
// Bench for snes_dejitter_core: line table plus hand sequences,
// CSYNC_o falls and gate windows tracked through expectation queues.
module tb_snes_dejitter_core;

    logic        clk = 1'b0;
    logic        RST_N_i;
    logic        BYPASS_i;
    logic        CSYNC_i;
    logic        CSYNC_o;
    logic        GCLK_EN_o;
    logic        SC_o;
    logic        LOCKED_o;
    logic [10:0] LINE_LEN_o;
    logic        STRETCH_o;

    always #5 clk = ~clk;

    snes_dejitter_core dut (
        .MCLK_i    (clk),
        .RST_N_i   (RST_N_i),
        .BYPASS_i  (BYPASS_i),
        .CSYNC_i   (CSYNC_i),
        .CSYNC_o   (CSYNC_o),
        .GCLK_EN_o (GCLK_EN_o),
        .SC_o      (SC_o),
        .LOCKED_o  (LOCKED_o),
        .LINE_LEN_o(LINE_LEN_o),
        .STRETCH_o (STRETCH_o)
    );

    typedef struct {
        int len;
        int kind;
        int chk_len;
        int exp_len;
        bit exp_lock;
        bit exp_st;
    } vec_t;

    typedef struct {
        int start;
        int len;
    } gate_t;

    int    checks = 0;
    int    errors = 0;
    int    ncyc = 0;
    int    fall_q[$];
    gate_t gate_q[$];
    vec_t  tbl[24];

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0d required %0d",
                     name, ncyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic  prev_cs = 1'b1;
    logic  prev_g = 1'b1;
    logic  prev_sc = 1'b0;
    bit    gate_on = 0;
    bit    sc_ok = 0;
    int    gate_from = 0;
    int    sc_last = 0;
    gate_t cur_gate;

    always @(negedge clk) begin
        if (prev_cs === 1'b1 && CSYNC_o === 1'b0) begin
            checks++;
            if (fall_q.size() == 0) begin
                errors++;
                $display("FAIL csync_fall: unexpected at %0d", ncyc);
            end else begin
                int e;
                e = fall_q.pop_front();
                if (e != ncyc) begin
                    errors++;
                    $display("FAIL csync_fall: at %0d required %0d",
                             ncyc, e);
                end
            end
        end
        if (prev_g === 1'b1 && GCLK_EN_o === 1'b0) begin
            checks++;
            if (gate_q.size() == 0) begin
                errors++;
                $display("FAIL gate_start: unexpected at %0d", ncyc);
            end else begin
                cur_gate  = gate_q.pop_front();
                gate_on   = 1;
                gate_from = ncyc;
                if (cur_gate.start != ncyc) begin
                    errors++;
                    $display("FAIL gate_start: at %0d required %0d",
                             ncyc, cur_gate.start);
                end
            end
        end
        if (prev_g === 1'b0 && GCLK_EN_o === 1'b1 && gate_on) begin
            checks++;
            gate_on = 0;
            if (ncyc - gate_from != cur_gate.len) begin
                errors++;
                $display("FAIL gate_len: got %0d required %0d",
                         ncyc - gate_from, cur_gate.len);
            end
        end
        if (STRETCH_o === 1'b1 ||
            (prev_g === 1'b1 && GCLK_EN_o === 1'b0)) begin
            checks++;
            if (STRETCH_o !== (prev_g & ~GCLK_EN_o)) begin
                errors++;
                $display("FAIL stretch_pulse @%0d: got %b required %b",
                         ncyc, STRETCH_o, prev_g & ~GCLK_EN_o);
            end
        end
        if (RST_N_i !== 1'b1) begin
            sc_ok = 0;
        end else if (SC_o !== prev_sc) begin
            if (sc_ok) begin
                checks++;
                if (ncyc - sc_last != 3) begin
                    errors++;
                    $display("FAIL sc_half_period: got %0d required 3",
                             ncyc - sc_last);
                end
            end
            sc_ok   = 1;
            sc_last = ncyc;
        end
        prev_cs = CSYNC_o;
        prev_g  = GCLK_EN_o;
        prev_sc = SC_o;
    end

    task automatic drive_line(input vec_t v);
        int k;
        bit low;
        k = ncyc;
        for (int i = 0; i < v.len; i++) begin
            low = (i < 100);
            if (v.kind == 1) begin
                low = (i < 40) || (i >= 100 && i < 120) ||
                      (i >= 600 && i < 620);
            end
            CSYNC_i = ~low;
            if (i == 0) begin
                fall_q.push_back(k + 3 + (v.exp_st ? 4 : 0));
                if (v.exp_st) gate_q.push_back('{k + 3, 4});
            end
            if (v.kind == 1 && (i == 100 || i == 600)) begin
                fall_q.push_back(ncyc + 3);
            end
            if (i == 5) begin
                if (v.chk_len != 0) chk("line_len", LINE_LEN_o, v.exp_len);
                chk("locked", LOCKED_o, v.exp_lock);
            end
            if (v.kind == 2 && i == 2000) chk("locked_pre_loss", LOCKED_o, 1);
            if (v.kind == 2 && i == v.len - 10) begin
                chk("locked_after_loss", LOCKED_o, 0);
            end
            step();
        end
    endtask

    initial begin
        int k, j, m;
        tbl[0]  = '{1364, 0, 0, 0,    1'b0, 1'b0};
        tbl[1]  = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[2]  = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[3]  = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[4]  = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[5]  = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[6]  = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[7]  = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[8]  = '{1364, 0, 1, 1360, 1'b1, 1'b1};
        tbl[9]  = '{1360, 0, 1, 1364, 1'b1, 1'b0};
        tbl[10] = '{1364, 0, 1, 1360, 1'b1, 1'b1};
        tbl[11] = '{2200, 2, 1, 1364, 1'b1, 1'b0};
        tbl[12] = '{1360, 0, 1, 2047, 1'b0, 1'b0};
        tbl[13] = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[14] = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[15] = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[16] = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[17] = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[18] = '{1360, 0, 1, 1364, 1'b0, 1'b0};
        tbl[19] = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[20] = '{1370, 1, 1, 1364, 1'b1, 1'b0};
        tbl[21] = '{1360, 0, 1, 1370, 1'b0, 1'b0};
        tbl[22] = '{1364, 0, 1, 1360, 1'b0, 1'b1};
        tbl[23] = '{1360, 0, 1, 1364, 1'b0, 1'b0};

        CSYNC_i  = 1'b1;
        BYPASS_i = 1'b0;
        RST_N_i  = 1'b0;
        step();
        step();
        step();
        chk("rst_csync_o", CSYNC_o, 1);
        chk("rst_gclk_en", GCLK_EN_o, 1);
        chk("rst_sc", SC_o, 0);
        chk("rst_locked", LOCKED_o, 0);
        chk("rst_line_len", LINE_LEN_o, 0);
        chk("rst_stretch", STRETCH_o, 0);

        RST_N_i = 1'b1;
        step();
        step();
        chk("sc_before_first_toggle", SC_o, 0);
        step();
        chk("sc_first_toggle", SC_o, 1);
        repeat (1100) step();

        for (int n = 0; n < 24; n++) drive_line(tbl[n]);

        k = ncyc;
        CSYNC_i = 1'b0;
        fall_q.push_back(k + 5);
        gate_q.push_back('{k + 3, 2});
        repeat (3) step();
        chk("byp_stretch_o", STRETCH_o, 1);
        step();
        chk("byp_gclk_low", GCLK_EN_o, 0);
        BYPASS_i = 1'b1;
        step();
        chk("byp_gclk_high", GCLK_EN_o, 1);
        repeat (15) step();
        CSYNC_i = 1'b1;
        repeat (10) step();
        for (int p = 0; p < 2; p++) begin
            m = ncyc;
            CSYNC_i = 1'b0;
            fall_q.push_back(m + 3);
            repeat (3) step();
            chk("byp_csync_low", CSYNC_o, 0);
            CSYNC_i = 1'b1;
            repeat (2) step();
            chk("byp_csync_hold", CSYNC_o, 0);
            step();
            chk("byp_csync_high", CSYNC_o, 1);
            chk("byp_locked", LOCKED_o, 0);
            repeat (5) step();
        end

        j = ncyc;
        BYPASS_i = 1'b0;
        while (ncyc < j + 1357) step();
        k = ncyc;
        for (int i = 0; i < 1360; i++) begin
            CSYNC_i = (i >= 100);
            if (i == 0) fall_q.push_back(k + 3);
            if (i == 5) begin
                chk("exit_byp_len", LINE_LEN_o, 1360);
                chk("exit_byp_locked", LOCKED_o, 0);
            end
            step();
        end

        k = ncyc;
        CSYNC_i = 1'b0;
        gate_q.push_back('{k + 3, 2});
        repeat (3) step();
        chk("rst_mid_stretch_o", STRETCH_o, 1);
        step();
        chk("rst_mid_gclk_low", GCLK_EN_o, 0);
        RST_N_i = 1'b0;
        CSYNC_i = 1'b1;
        step();
        chk("rst_mid_gclk_high", GCLK_EN_o, 1);
        step();
        step();
        RST_N_i = 1'b1;
        step();
        chk("post_rst_locked", LOCKED_o, 0);
        chk("post_rst_line_len", LINE_LEN_o, 0);
        chk("post_rst_csync", CSYNC_o, 1);
        repeat (30) step();

        chk("fall_q_drained", fall_q.size(), 0);
        chk("gate_q_drained", gate_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
